int_fp_mul_trace_capture: RTL and testbench

- Hardware writer for the 49-bit golden-pattern vector format {input1, input2, result, mode} used by our int_fp_mul pattern benches.
- Snoops the operand/result bus of int_fp_mul and captures tuples into an internal buffer. A read port drains them so the captured stream can be dumped as new golden or regression patterns.
- Also counts captured samples whose multiplier error flag was set.
- Sits beside int_fp_mul in the MAC datapath as a debug/trace block.

---
 rtl/int_fp_mul_trace_capture.sv | 174 +++++++++++++++++
 tb/tb_int_fp_mul_trace_capture.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/int_fp_mul_trace_capture.sv
// Trace capture buffer for the int_fp_mul operand/result bus.
// Stores {input1, input2, result, mode} tuples in a small circular buffer that
// can be drained through a registered read port. Also counts stored samples
// that carried the multiplier error flag.
module int_fp_mul_trace_capture #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          wrap_en,
    input  logic          cap_valid,
    input  logic          mode,
    input  logic [15:0]   input1,
    input  logic [15:0]   input2,
    input  logic [15:0]   result,
    input  logic          error,
    input  logic          rd_en,
    output logic [48:0]   rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [7:0]    err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]    ERR_MAX   = 8'hFF;

    state_t        state_r, state_s;
    logic [AW-1:0] wr_ptr_r, wr_ptr_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_s;
    logic [AW:0]   count_r, count_s;
    logic          overflow_r, overflow_s;
    logic [7:0]    err_cnt_r, err_cnt_s;
    logic [48:0]   rd_data_r;
    logic          rd_valid_r;
    logic          busy_r;
    logic          done_r;
    logic          wr_req_s;
    logic          rd_acc_s;
    logic          wr_do_s;
    logic          full_s;
    logic [48:0]   mem_r [DEPTH];

    // Next-state computation: pointers, occupancy, sticky flags and FSM.
    always_comb begin
        state_s    = state_r;
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        overflow_s = overflow_r;
        err_cnt_s  = err_cnt_r;
        wr_do_s    = 1'b0;
        full_s     = (count_r == DEPTH_CNT);
        // start wins over everything in its cycle, including reads and samples
        wr_req_s   = (state_r == ST_CAPTURE) && cap_valid && !start;
        rd_acc_s   = rd_en && (count_r != CNT_ZERO) && !start;

        if (start) begin
            wr_ptr_s   = {AW{1'b0}};
            rd_ptr_s   = {AW{1'b0}};
            count_s    = CNT_ZERO;
            overflow_s = 1'b0;
            err_cnt_s  = 8'h00;
            state_s    = ST_CAPTURE;
        end else begin
            if (wr_req_s && rd_acc_s) begin
                // read frees the oldest slot, so no overwrite even when full
                wr_do_s  = 1'b1;
                wr_ptr_s = wr_ptr_r + PTR_ONE;
                rd_ptr_s = rd_ptr_r + PTR_ONE;
            end else if (wr_req_s) begin
                if (!full_s) begin
                    wr_do_s  = 1'b1;
                    wr_ptr_s = wr_ptr_r + PTR_ONE;
                    count_s  = count_r + CNT_ONE;
                end else if (wrap_en) begin
                    wr_do_s    = 1'b1;
                    wr_ptr_s   = wr_ptr_r + PTR_ONE;
                    rd_ptr_s   = rd_ptr_r + PTR_ONE;
                    overflow_s = 1'b1;
                end else begin
                    // full, no wrap (wrap_en dropped while full): sample lost
                    overflow_s = 1'b1;
                end
            end else if (rd_acc_s) begin
                rd_ptr_s = rd_ptr_r + PTR_ONE;
                count_s  = count_r - CNT_ONE;
            end else begin
                count_s = count_r;
            end

            if (wr_do_s && error && (err_cnt_r != ERR_MAX)) begin
                err_cnt_s = err_cnt_r + 8'd1;
            end else begin
                err_cnt_s = err_cnt_r;
            end

            case (state_r)
                ST_CAPTURE: begin
                    if (stop || (!wrap_en && (count_s == DEPTH_CNT))) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end
                ST_IDLE:  state_s = ST_IDLE;
                ST_DONE:  state_s = ST_DONE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // Control/status registers and the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
            err_cnt_r  <= 8'h00;
            rd_data_r  <= 49'd0;
            rd_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            overflow_r <= overflow_s;
            err_cnt_r  <= err_cnt_s;
            rd_valid_r <= rd_acc_s;
            busy_r     <= (state_s == ST_CAPTURE);
            done_r     <= (state_s == ST_DONE);
            if (rd_acc_s) begin
                // pre-edge memory value: a same-slot write lands after this read
                rd_data_r <= mem_r[rd_ptr_r];
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_do_s) begin
            mem_r[wr_ptr_r] <= {input1, input2, result, mode};
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign count    = count_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_int_fp_mul_trace_capture.sv
// Directed bench for int_fp_mul_trace_capture with a queue-based scoreboard.
module tb_int_fp_mul_trace_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, wrap_en, cap_valid, mode, error, rd_en;
    logic [15:0] input1, input2, result;
    logic [48:0] rd_data;
    logic        rd_valid, busy, done, overflow;
    logic [4:0]  count;
    logic [7:0]  err_cnt;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Scoreboard: entries the buffer should hold, oldest first.
    logic [48:0] exp_q[$];
    int          m_state;   // 0 idle, 1 capture, 2 done
    bit          m_ovf;
    int          m_err;

    int_fp_mul_trace_capture #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .wrap_en(wrap_en),
        .cap_valid(cap_valid), .mode(mode), .input1(input1), .input2(input2),
        .result(result), .error(error), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .count(count), .busy(busy), .done(done),
        .overflow(overflow), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".count"},    64'(count),    64'(exp_q.size()));
        chk({tag, ".busy"},     64'(busy),     64'(m_state == 1));
        chk({tag, ".done"},     64'(done),     64'(m_state == 2));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".err_cnt"},  64'(err_cnt),  64'(m_err));
    endtask

    // One clock cycle of stimulus; model updated, then outputs checked after the edge.
    task automatic step(input string tag, input bit s, input bit st, input bit cv, input bit re,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                        input bit m, input bit e);
        bit          rd_ok;
        bit          wr_ok;
        logic [48:0] rexp;
        rd_ok = 1'b0;
        rexp  = 49'd0;
        start = s; stop = st; cap_valid = cv; rd_en = re;
        input1 = a; input2 = b; result = r; mode = m; error = e;
        if (s) begin
            exp_q.delete();
            m_ovf   = 1'b0;
            m_err   = 0;
            m_state = 1;
        end else begin
            rd_ok = re && (exp_q.size() > 0);
            wr_ok = (m_state == 1) && cv;
            if (rd_ok) rexp = exp_q.pop_front();
            if (wr_ok) begin
                if (exp_q.size() < 16) begin
                    exp_q.push_back({a, b, r, m});
                    if (e && m_err < 255) m_err++;
                end else if (wrap_en) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back({a, b, r, m});
                    m_ovf = 1'b1;
                    if (e && m_err < 255) m_err++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_state == 1 && (st || (!wrap_en && exp_q.size() == 16))) m_state = 2;
        end
        @(posedge clk);
        #1;
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(rd_ok));
        if (rd_ok) chk({tag, ".rd_data"}, 64'(rd_data), 64'(rexp));
        chk_status(tag);
    endtask

    task automatic wr(input string tag, input logic [15:0] a, input bit e);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b0, a, 16'h1234, 16'h5678, 1'b0, e);
    endtask

    task automatic rd(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic go(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; wrap_en = 1'b0; cap_valid = 1'b0;
        mode = 1'b0; error = 1'b0; rd_en = 1'b0;
        input1 = 16'h0000; input2 = 16'h0000; result = 16'h0000;
        m_state = 0; m_ovf = 1'b0; m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rd_valid", 64'(rd_valid), 64'd0);
        chk("reset.rd_data",  64'(rd_data),  64'd0);
        chk_status("reset");
        rst_n = 1'b1;

        // Basic capture of three identical samples, then drain.
        go("t1.start");
        for (int i = 0; i < 3; i++)
            step("t1.wr", 1'b0, 1'b0, 1'b1, 1'b0, 16'h3C00, 16'h4000, 16'h4000, 1'b1, 1'b0);
        chk("t1.count3", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            rd("t1.rd");
            chk("t1.rd_const", 64'(rd_data), 64'({16'h3C00, 16'h4000, 16'h4000, 1'b1}));
        end
        chk("t1.count0", 64'(count), 64'd0);

        // No-wrap: capture stops at 16 entries.
        wrap_en = 1'b0;
        go("t2.start");
        for (int i = 0; i < 20; i++) begin
            wr("t2.wr", 16'(i), 1'b0);
            if (i == 15) chk("t2.done_at16", 64'(done), 64'd1);
        end
        for (int i = 0; i < 16; i++) begin
            rd("t2.rd");
            chk("t2.rd_in1", 64'(rd_data[48:33]), 64'(i));
        end
        rd("t2.rd_empty");

        // Wrap: oldest four overwritten.
        wrap_en = 1'b1;
        go("t3.start");
        for (int i = 0; i < 20; i++) wr("t3.wr", 16'(i), 1'b0);
        chk("t3.overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            rd("t3.rd");
            chk("t3.rd_in1", 64'(rd_data[48:33]), 64'(i + 4));
        end

        // Error counter saturation, then cleared by start.
        go("t4.start");
        for (int i = 0; i < 300; i++) wr("t4.wr", 16'(i), 1'b1);
        chk("t4.err_sat", 64'(err_cnt), 64'd255);
        go("t4.restart");
        chk("t4.err_clr", 64'(err_cnt), 64'd0);

        // Full buffer with simultaneous read and write: no overwrite.
        go("t5.start");
        for (int i = 0; i < 16; i++) wr("t5.wr", 16'(100 + i), 1'b0);
        step("t5.rdwr", 1'b0, 1'b0, 1'b1, 1'b1, 16'd200, 16'h1234, 16'h5678, 1'b0, 1'b0);
        chk("t5.oldest", 64'(rd_data[48:33]), 64'd100);
        chk("t5.count16", 64'(count), 64'd16);
        chk("t5.no_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 16; i++) rd("t5.drain");
        rd("t5.rd_empty");

        // Stop pulse, then samples in DONE ignored.
        go("t6.start");
        wr("t6.wr", 16'd7, 1'b0);
        step("t6.stop", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        wr("t6.wr_done", 16'd8, 1'b0);

        // Asynchronous reset mid-capture.
        go("t7.start");
        for (int i = 0; i < 5; i++) wr("t7.wr", 16'(i), 1'b1);
        chk("t7.count5", 64'(count), 64'd5);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_state = 0; m_ovf = 1'b0; m_err = 0;
        #1;
        chk("t7.async.rd_valid", 64'(rd_valid), 64'd0);
        chk("t7.async.rd_data",  64'(rd_data),  64'd0);
        chk_status("t7.async");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr("t7.wr_idle", 16'd9, 1'b1);
        rd("t7.rd_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
